pipe_addsub: RTL and testbench

- Parametrised, pipelined successor to the 8-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit carry-chained stages, one register stage per chunk.
- Valid/ready handshake on input and output; produces carry, signed overflow and zero flags.
- Used as the shared arithmetic unit feeding datapath blocks that need more than 8 bits at clock rate.

---
 rtl/pipe_addsub_pkg.sv | 12 +
 rtl/pipe_addsub_add_chunk.sv | 28 ++
 rtl/pipe_addsub.sv | 167 ++++++++++++++++
 tb/tb_pipe_addsub.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings and
// the stage-count helper used to size the pipeline.
package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipe_addsub_add_chunk.sv
// Combinational CHUNK-bit ripple-carry chain built from full-adder cells;
// also exposes the carry into the top bit so the caller can form signed overflow.
module add_chunk
    import pipe_addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit carry-chained stage per register
// rank, valid/ready handshake. Define PIPE_ADDSUB_SAT_EN to saturate on signed overflow.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPE_ADDSUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] raw,
                                                  input logic ovf_in);
        logic [WIDTH-1:0] lim;
        // Wrapped MSB of 1 means the true result was too positive, and vice versa.
        lim = {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}};
        return ovf_in ? lim : raw;
    endfunction
`endif

    // Subtract is a + ~b + 1; cin only matters for add.
    assign b_eff   = (op == OP_SUB) ? ~b : b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;

    // in_ready is combinational from out_ready through the ready chain.
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = WIDTH - (k + 1) * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [CHUNK-1:0] x_chunk;
        logic [CHUNK-1:0] y_chunk;
        logic [CHUNK-1:0] s_chunk;
        logic             src_c;
        logic             src_v;
        logic             co;
        logic             vld_q;
        logic [SW-1:0]    nxt_s;

        if (k == 0) begin : g_src
            assign x_chunk = a[CHUNK-1:0];
            assign y_chunk = b_eff[CHUNK-1:0];
            assign src_c   = cin_eff;
            assign src_v   = in_valid;
            assign nxt_s   = s_chunk;
        end else begin : g_src
            assign x_chunk = g_stage[k-1].g_mid.a_q[CHUNK-1:0];
            assign y_chunk = g_stage[k-1].g_mid.b_q[CHUNK-1:0];
            assign src_c   = g_stage[k-1].g_mid.c_q;
            assign src_v   = g_stage[k-1].vld_q;
            assign nxt_s   = {s_chunk, g_stage[k-1].g_mid.s_q};
        end

        assign rdy[k] = ~vld_q | rdy[k+1];

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else if (rdy[k]) begin
                vld_q <= src_v;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic             c_msb_unused;
            logic [RW-1:0]    a_up;
            logic [RW-1:0]    b_up;
            logic [RW-1:0]    a_q;
            logic [RW-1:0]    b_q;
            logic [SW-1:0]    s_q;
            logic             c_q;

            add_chunk #(.CHUNK(CHUNK)) u_add (
                .x        (x_chunk),
                .y        (y_chunk),
                .ci       (src_c),
                .s        (s_chunk),
                .co       (co),
                .c_msb_in (c_msb_unused)
            );

            // Unconsumed operand chunks ride along, shrinking by one chunk per stage.
            if (k == 0) begin : g_up
                assign a_up = a[WIDTH-1:CHUNK];
                assign b_up = b_eff[WIDTH-1:CHUNK];
            end else begin : g_up
                assign a_up = g_stage[k-1].g_mid.a_q[RW+CHUNK-1:CHUNK];
                assign b_up = g_stage[k-1].g_mid.b_q[RW+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (rdy[k] && src_v) begin
                    a_q <= a_up;
                    b_q <= b_up;
                    s_q <= nxt_s;
                    c_q <= co;
                end
            end
        end else begin : g_last
            logic             c_msb;
            logic             ovf_n;
            logic [WIDTH-1:0] fin;

            add_chunk #(.CHUNK(CHUNK)) u_add (
                .x        (x_chunk),
                .y        (y_chunk),
                .ci       (src_c),
                .s        (s_chunk),
                .co       (co),
                .c_msb_in (c_msb)
            );

            assign ovf_n = c_msb ^ co;
`ifdef PIPE_ADDSUB_SAT_EN
            assign fin = sat_sum(nxt_s, ovf_n);
`else
            assign fin = nxt_s;
`endif

            // ---- final stage: result and flags registered together ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum  <= '0;
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                    zero <= 1'b0;
                end else if (rdy[k] && src_v) begin
                    sum  <= fin;
                    cout <= co;
                    ovf  <= ovf_n;
                    zero <= ~|fin;
                end
            end

            assign out_valid = vld_q;
        end
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and streamed checks of pipe_addsub at WIDTH=8, CHUNK=4 (latency 2);
// expectations follow PIPE_ADDSUB_SAT_EN when the bench is built with it.
module tb_pipe_addsub;

    localparam int WIDTH = 8;
    localparam int CHUNK = 4;

`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [7:0] POS_OVF_SUM = 8'h7F;
    localparam logic [7:0] NEG_OVF_SUM = 8'h80;
`else
    localparam logic [7:0] POS_OVF_SUM = 8'h80;
    localparam logic [7:0] NEG_OVF_SUM = 8'h7F;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  bvals [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    pipe_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Arithmetic reference: {sum, cout, ovf, zero}
    function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mc, input logic mo);
        int ua, ub, sa, sb, r, rs;
        logic [7:0] s;
        logic c, o;
        ua = ma;
        ub = mb;
        sa = $signed(ma);
        sb = $signed(mb);
        if (mo == 1'b0) begin
            r  = ua + ub + mc;
            c  = (r > 255);
            rs = sa + sb + mc;
        end else begin
            r  = ua - ub;
            c  = (ua >= ub);
            rs = sa - sb;
        end
        s = r[7:0];
        o = (rs > 127) || (rs < -128);
`ifdef PIPE_ADDSUB_SAT_EN
        if (o) s = (rs > 127) ? 8'h7F : 8'h80;
`endif
        return {s, c, o, (s == 8'h00)};
    endfunction

    task automatic gen(input int mode, input int idx);
        if (mode == 2) begin
            a = idx[7:0];
            b = bvals[(idx >> 8) & 7];
            case (idx >> 11)
                0:       begin cin = 1'b0;   op = 1'b0; end
                1:       begin cin = 1'b1;   op = 1'b0; end
                default: begin cin = idx[0]; op = 1'b1; end
            endcase
        end else begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            op  = 1'($urandom);
        end
    endtask

    task automatic directed(input string tag, input logic [7:0] va, input logic [7:0] vb,
                            input logic vc, input logic vo, input logic [10:0] expv);
        @(negedge clk);
        a = va; b = vb; cin = vc; op = vo;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " latency"}, out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, " valid"}, out_valid, 1'b1);
        chk(tag, {sum, cout, ovf, zero}, expv);
        @(posedge clk); #1;
        chk({tag, " drained"}, out_valid, 1'b0);
    endtask

    // mode 0: random at full rate; mode 1: random with out_ready low for the
    // first 5 cycles; mode 2: sweep of every a against a set of b values.
    task automatic run_stream(input int n, input int mode, input string tag);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stall_acc = 0;
        bit took = 1'b0;
        bit have_hold = 1'b0;
        logic [10:0] hold;
        logic [10:0] obs;
        exp_q.delete();
        while (got < n && cyc < n * 4 + 50) begin
            @(negedge clk);
            out_ready = !(mode == 1 && cyc < 5);
            if (!in_valid || took) begin
                took = 1'b0;
                if (sent < n) begin
                    gen(mode, sent);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            obs = {sum, cout, ovf, zero};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " unexpected result"}, 32'd1, 32'd0);
                end else begin
                    chk({tag, " result"}, obs, exp_q.pop_front());
                end
                got++;
            end
            if (mode == 1 && !out_ready && out_valid) begin
                if (have_hold) chk({tag, " stable"}, obs, hold);
                else begin
                    hold = obs;
                    have_hold = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, op));
                sent++;
                took = 1'b1;
                if (!out_ready) stall_acc++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, " count"}, got, n);
        chk({tag, " leftover"}, exp_q.size(), 0);
        if (mode != 1) chk({tag, " throughput cycles"}, cyc, n + 2);
        if (mode == 1) chk({tag, " accepts while stalled"}, stall_acc, 2);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0; op = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b1);
        chk("reset outputs", {sum, cout, ovf, zero}, 11'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        directed("add 03+02+1",   8'h03, 8'h02, 1'b1, 1'b0, {8'h06, 1'b0, 1'b0, 1'b0});
        directed("add FF+01 wrap", 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});
        directed("add 7F+01 ovf", 8'h7F, 8'h01, 1'b0, 1'b0, {POS_OVF_SUM, 1'b0, 1'b1, 1'b0});
        directed("add 0F+00+1",   8'h0F, 8'h00, 1'b1, 1'b0, {8'h10, 1'b0, 1'b0, 1'b0});
        directed("add 80+FF ovf", 8'h80, 8'hFF, 1'b0, 1'b0, {NEG_OVF_SUM, 1'b1, 1'b1, 1'b0});
        directed("sub 05-07",     8'h05, 8'h07, 1'b0, 1'b1, {8'hFE, 1'b0, 1'b0, 1'b0});
        directed("sub 80-01 ovf", 8'h80, 8'h01, 1'b0, 1'b1, {NEG_OVF_SUM, 1'b1, 1'b1, 1'b0});
        directed("sub 05-05",     8'h05, 8'h05, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0, 1'b1});
        directed("sub 10-01 cin", 8'h10, 8'h01, 1'b1, 1'b1, {8'h0F, 1'b1, 1'b0, 1'b0});

        run_stream(256, 0, "stream");
        run_stream(20, 1, "stall");
        run_stream(6144, 2, "sweep");

        // Two operations in flight, then an asynchronous reset.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; op = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        a = 8'h33; b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("inflight out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid, 1'b0);
        chk("midreset outputs", {sum, cout, ovf, zero}, 11'h000);
        chk("midreset in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post-reset idle", out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
